// File: rtl/uart_tx_ctrl_pkg.sv
// Shared UART definitions: frame state encoding, frame configuration and data width limits.
// Used by both the TX sequencer and its bit timer.
package uart_tx_ctrl_pkg;

    localparam int DEFAULT_OVERSAMPLE = 16;
    localparam int DEFAULT_DATA_BITS  = 8;
    localparam int DATA_BITS_MIN      = 5;
    localparam int DATA_BITS_MAX      = 8;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } tx_state_t;

    // Per-frame options captured together with the data byte.
    typedef struct packed {
        logic parity_en;
        logic parity_odd;
        logic stop2;
    } frame_cfg_t;

    // Even parity makes the total count of ones even; odd parity inverts it.
    // Unused upper data bits must be zero.
    function automatic logic parity_bit(input logic [DATA_BITS_MAX-1:0] data,
                                        input logic odd);
        return (^data) ^ odd;
    endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// Counts baud ticks within one serial bit and flags the tick that ends the bit.
// clear holds the count at zero so a new frame always starts on a full bit.
module uart_bit_timer
    import uart_tx_ctrl_pkg::*;
#(
    parameter int OVERSAMPLE = DEFAULT_OVERSAMPLE
) (
    input  logic clk,
    input  logic rst,
    input  logic en_tx,
    input  logic clear,
    output logic bit_end
);

    localparam int TW = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
    localparam logic [TW-1:0] LAST_TICK = TW'(OVERSAMPLE - 1);

    logic [TW-1:0] tick_cnt_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tick_cnt_reg <= '0;
        end else if (clear) begin
            tick_cnt_reg <= '0;
        end else if (en_tx) begin
            if (tick_cnt_reg == LAST_TICK) begin
                tick_cnt_reg <= '0;
            end else begin
                tick_cnt_reg <= tick_cnt_reg + 1'b1;
            end
        end
    end

    assign bit_end = en_tx && !clear && (tick_cnt_reg == LAST_TICK);

endmodule

// File: rtl/uart_tx_ctrl.sv
// UART transmit sequencer: 1-entry holding register feeding a start/data/parity/stop
// serialiser paced by the oversampled baud tick.
module uart_tx_ctrl
    import uart_tx_ctrl_pkg::*;
#(
    parameter int DATA_BITS  = DEFAULT_DATA_BITS,
    parameter int OVERSAMPLE = DEFAULT_OVERSAMPLE
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en_tx,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    input  logic                 parity_en,
    input  logic                 parity_odd,
    input  logic                 stop2,
    output logic                 txd,
    output logic                 busy,
    output logic                 done
);

    localparam logic [2:0] LAST_DATA_BIT = 3'(DATA_BITS - 1);

    tx_state_t              state_reg;
    logic                   txd_reg;
    logic                   done_reg;
    logic                   hold_full_reg;
    logic [DATA_BITS-1:0]   hold_data_reg;
    frame_cfg_t             hold_cfg_reg;
    logic [DATA_BITS-1:0]   shift_reg;
    logic                   frame_par_en_reg;
    logic                   frame_stop2_reg;
    logic                   parity_reg;
    logic [2:0]             bit_cnt_reg;

    logic                     bit_end;
    logic                     timer_clear;
    logic                     last_stop;
    logic                     load_frame;
    logic [DATA_BITS_MAX-1:0] hold_data_ext;

    // Zero-pad the held byte to the widest frame so one parity helper serves all widths.
    genvar gi;
    generate
        for (gi = 0; gi < DATA_BITS_MAX; gi++) begin : g_ext
            if (gi < DATA_BITS) begin : g_bit
                assign hold_data_ext[gi] = hold_data_reg[gi];
            end else begin : g_pad
                assign hold_data_ext[gi] = 1'b0;
            end
        end
    endgenerate

    assign timer_clear = (state_reg == ST_IDLE);
    assign last_stop   = !frame_stop2_reg || (bit_cnt_reg == 3'd1);

    // A held byte starts either from idle on a baud tick or straight after the last stop bit.
    assign load_frame = hold_full_reg &&
                        (((state_reg == ST_IDLE) && en_tx) ||
                         ((state_reg == ST_STOP) && bit_end && last_stop));

    uart_bit_timer #(
        .OVERSAMPLE (OVERSAMPLE)
    ) u_bit_timer (
        .clk     (clk),
        .rst     (rst),
        .en_tx   (en_tx),
        .clear   (timer_clear),
        .bit_end (bit_end)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg        <= ST_IDLE;
            txd_reg          <= 1'b1;
            done_reg         <= 1'b0;
            hold_full_reg    <= 1'b0;
            hold_data_reg    <= '0;
            hold_cfg_reg     <= '0;
            shift_reg        <= '0;
            frame_par_en_reg <= 1'b0;
            frame_stop2_reg  <= 1'b0;
            parity_reg       <= 1'b0;
            bit_cnt_reg      <= '0;
        end else begin
            done_reg <= 1'b0;

            if (tx_valid && !hold_full_reg) begin
                hold_full_reg           <= 1'b1;
                hold_data_reg           <= tx_data;
                hold_cfg_reg.parity_en  <= parity_en;
                hold_cfg_reg.parity_odd <= parity_odd;
                hold_cfg_reg.stop2      <= stop2;
            end

            if (load_frame) begin
                shift_reg        <= hold_data_reg;
                frame_par_en_reg <= hold_cfg_reg.parity_en;
                frame_stop2_reg  <= hold_cfg_reg.stop2;
                parity_reg       <= parity_bit(hold_data_ext, hold_cfg_reg.parity_odd);
                hold_full_reg    <= 1'b0;
                done_reg         <= (state_reg == ST_STOP);
                txd_reg          <= 1'b0;
                bit_cnt_reg      <= '0;
                state_reg        <= ST_START;
            end else begin
                case (state_reg)
                    ST_IDLE: begin
                        txd_reg <= 1'b1;
                    end
                    ST_START: begin
                        if (bit_end) begin
                            txd_reg     <= shift_reg[0];
                            bit_cnt_reg <= '0;
                            state_reg   <= ST_DATA;
                        end
                    end
                    ST_DATA: begin
                        if (bit_end) begin
                            if (bit_cnt_reg == LAST_DATA_BIT) begin
                                bit_cnt_reg <= '0;
                                if (frame_par_en_reg) begin
                                    txd_reg   <= parity_reg;
                                    state_reg <= ST_PARITY;
                                end else begin
                                    txd_reg   <= 1'b1;
                                    state_reg <= ST_STOP;
                                end
                            end else begin
                                shift_reg   <= shift_reg >> 1;
                                txd_reg     <= shift_reg[1];
                                bit_cnt_reg <= bit_cnt_reg + 3'd1;
                            end
                        end
                    end
                    ST_PARITY: begin
                        if (bit_end) begin
                            txd_reg     <= 1'b1;
                            bit_cnt_reg <= '0;
                            state_reg   <= ST_STOP;
                        end
                    end
                    ST_STOP: begin
                        // bit_cnt counts completed stop bits when two are configured.
                        if (bit_end) begin
                            if (last_stop) begin
                                done_reg  <= 1'b1;
                                txd_reg   <= 1'b1;
                                state_reg <= ST_IDLE;
                            end else begin
                                bit_cnt_reg <= 3'd1;
                            end
                        end
                    end
                    default: begin
                        txd_reg   <= 1'b1;
                        state_reg <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    assign tx_ready = ~hold_full_reg;
    assign busy     = (state_reg != ST_IDLE);
    assign txd      = txd_reg;
    assign done     = done_reg;

endmodule
